// File: rtl/mips_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package mips_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_e;

  localparam int unsigned LOADER_WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into instruction-memory
// writes and holds the core in reset until the image is written and verified.
module imem_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  loader_state_e state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept;
  logic [15:0] len_rx;

  assign accept = in_valid && in_ready;
  assign len_rx = {len_q[15:8], in_byte};

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    csum_d   = csum_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    in_ready = 1'b0;

    unique case (state_q)
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (accept) begin
          len_d   = {in_byte, 8'h00};
          csum_d  = csum_q ^ in_byte;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          len_d  = len_rx;
          csum_d = csum_q ^ in_byte;
          if (32'(len_rx) > MAX_WORDS) begin
            state_d = S_ERR;
          end else if (len_rx == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (accept) begin
          csum_d = csum_q ^ in_byte;
          word_d = {word_q[15:0], in_byte};
          cnt_d  = cnt_q + 2'd1;
          // Latch address and data up front so both are stable through the strobe cycle.
          if (cnt_q == 2'(LOADER_WORD_BYTES - 1)) begin
            addr_d  = BASE_ADDR + (32'(idx_q) << 2);
            wdata_d = {word_q, in_byte};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = ((idx_q + 16'd1) == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        in_ready = 1'b1;
        if (accept) begin
          state_d = (in_byte == csum_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LEN_HI;
      len_q   <= 16'd0;
      idx_q   <= 16'd0;
      cnt_q   <= 2'd0;
      word_q  <= 24'd0;
      csum_q  <= 8'd0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);

endmodule
